board_writer: RTL and testbench

//  Write side of the playfield store. On each at_bottom pulse it locks the four

---
 rtl/board_writer_if.sv | 41 ++++
 rtl/board_writer.sv | 162 ++++++++++++++++
 tb/tb_board_writer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_writer_if.sv
// Playfield bus: lock request and coordinates in, grid read port and status out.
interface board_writer_if #(
  parameter int COLS = 10
);
  logic            clear_board;
  logic            at_bottom;
  logic [9:0]      square1x;
  logic [9:0]      square1y;
  logic [9:0]      square2x;
  logic [9:0]      square2y;
  logic [9:0]      square3x;
  logic [9:0]      square3y;
  logic [9:0]      square4x;
  logic [9:0]      square4y;
  logic [4:0]      rd_row;
  logic [COLS-1:0] rd_cells;
  logic            busy;
  logic            done;
  logic [2:0]      lines_cleared;
  logic [15:0]     lines_total;
  logic            oob;
  logic            game_over;

  // Game logic / color_mapper side
  modport master (
    output clear_board, at_bottom,
    output square1x, square1y, square2x, square2y,
    output square3x, square3y, square4x, square4y,
    output rd_row,
    input  rd_cells, busy, done, lines_cleared, lines_total, oob, game_over
  );

  // Playfield store side
  modport slave (
    input  clear_board, at_bottom,
    input  square1x, square1y, square2x, square2y,
    input  square3x, square3y, square4x, square4y,
    input  rd_row,
    output rd_cells, busy, done, lines_cleared, lines_total, oob, game_over
  );
endinterface

// File: rtl/board_writer.sv
// Playfield write side: locks a landed piece into the cell grid, removes full
// rows by shifting everything above them down, and serves a registered row read.
module board_writer #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int CELL_LOG2 = 4,
  parameter int ORIG_X    = 240,
  parameter int ORIG_Y    = 80
) (
  input  logic          Clk,
  input  logic          Reset,
  board_writer_if.slave bus
);
  localparam int RW = $clog2(ROWS);   // row index width
  localparam int OW = 11 - CELL_LOG2; // width of a pixel offset after the cell shift

  typedef enum logic [2:0] {
    S_IDLE, S_LOCK1, S_LOCK2, S_LOCK3, S_LOCK4, S_SCAN, S_SHIFT, S_DONE
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   r_q;
  logic [COLS-1:0] grid_q [ROWS];
  logic [9:0]      sq_x_q [4];
  logic [9:0]      sq_y_q [4];
  logic [COLS-1:0] rd_cells_q;
  logic            busy_q;
  logic            done_q;
  logic            oob_q;
  logic            game_over_q;
  logic [2:0]      lines_cleared_q;
  logic [15:0]     lines_total_q;

  // Per-row "every cell occupied" flags used by the scan
  logic [ROWS-1:0] row_full;
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_full
      assign row_full[gi] = &grid_q[gi];
    end
  endgenerate

  logic [1:0]      lock_idx;
  logic            lock_active;
  logic [10:0]     lock_dx;
  logic [10:0]     lock_dy;
  logic [OW-1:0]   lock_col;
  logic [OW-1:0]   lock_row;
  logic            lock_ok;
  logic [COLS-1:0] lock_mask;

  // Map the square selected by the current LOCKn state to a cell and bounds-check it
  always_comb begin
    lock_idx    = 2'd0;
    lock_active = 1'b1;
    case (state_q)
      S_LOCK1: lock_idx = 2'd0;
      S_LOCK2: lock_idx = 2'd1;
      S_LOCK3: lock_idx = 2'd2;
      S_LOCK4: lock_idx = 2'd3;
      default: lock_active = 1'b0;
    endcase
    // 11-bit subtraction: bit 10 set means the square is left of / above the grid
    lock_dx   = {1'b0, sq_x_q[lock_idx]} - 11'(ORIG_X);
    lock_dy   = {1'b0, sq_y_q[lock_idx]} - 11'(ORIG_Y);
    lock_col  = OW'(lock_dx >> CELL_LOG2);
    lock_row  = OW'(lock_dy >> CELL_LOG2);
    lock_ok   = !lock_dx[10] && !lock_dy[10] &&
                (lock_col < OW'(COLS)) && (lock_row < OW'(ROWS));
    lock_mask = {{(COLS-1){1'b0}}, 1'b1} << lock_col;
  end

  // Sequencer, grid storage, read port and registered status outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= S_IDLE;
      r_q             <= '0;
      for (int i = 0; i < ROWS; i++) grid_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        sq_x_q[i] <= '0;
        sq_y_q[i] <= '0;
      end
      rd_cells_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      oob_q           <= 1'b0;
      game_over_q     <= 1'b0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
    end else begin
      // Reads are never blocked; while busy they expose the grid mid-update
      rd_cells_q <= ({1'b0, bus.rd_row} < 6'(ROWS)) ? grid_q[bus.rd_row] : '0;
      done_q     <= 1'b0;

      // Out-of-grid squares are dropped but flagged; the rest still land
      if (lock_active) begin
        if (lock_ok) grid_q[lock_row[RW-1:0]] <= grid_q[lock_row[RW-1:0]] | lock_mask;
        else         oob_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.clear_board) begin
            // A wipe takes priority over a landing in the same cycle
            for (int i = 0; i < ROWS; i++) grid_q[i] <= '0;
            oob_q       <= 1'b0;
            game_over_q <= 1'b0;
          end else if (bus.at_bottom) begin
            sq_x_q[0]       <= bus.square1x;
            sq_y_q[0]       <= bus.square1y;
            sq_x_q[1]       <= bus.square2x;
            sq_y_q[1]       <= bus.square2y;
            sq_x_q[2]       <= bus.square3x;
            sq_y_q[2]       <= bus.square3y;
            sq_x_q[3]       <= bus.square4x;
            sq_y_q[3]       <= bus.square4y;
            busy_q          <= 1'b1;
            lines_cleared_q <= '0;
            state_q         <= S_LOCK1;
          end
        end
        S_LOCK1: state_q <= S_LOCK2;
        S_LOCK2: state_q <= S_LOCK3;
        S_LOCK3: state_q <= S_LOCK4;
        S_LOCK4: begin
          r_q     <= RW'(ROWS - 1);
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full[r_q])  state_q <= S_SHIFT;
          else if (r_q == '0) state_q <= S_DONE;
          else                r_q     <= r_q - 1'b1;
        end
        S_SHIFT: begin
          // Rows 0..r-1 drop one place; r is rescanned since it now holds new content
          for (int i = 1; i < ROWS; i++) begin
            if (RW'(i) <= r_q) grid_q[i] <= grid_q[i-1];
          end
          grid_q[0]       <= '0;
          lines_cleared_q <= lines_cleared_q + 3'd1;
          if (lines_total_q != 16'hFFFF) lines_total_q <= lines_total_q + 16'd1;
          state_q         <= S_SCAN;
        end
        S_DONE: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          game_over_q <= game_over_q | (|grid_q[0]);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_cells      = rd_cells_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_cleared_q;
  assign bus.lines_total   = lines_total_q;
  assign bus.oob           = oob_q;
  assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: a landing-level playfield model checked
// every cycle, plus directed drops with hand-computed grid contents and latencies.
module tb_board_writer;
  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  board_writer_if #(.COLS(COLS)) bus();

  board_writer #(
    .COLS(COLS), .ROWS(ROWS), .CELL_LOG2(4), .ORIG_X(240), .ORIG_Y(80)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- playfield model (whole landing at once) ----------------
  logic [COLS-1:0] m_grid [ROWS];
  int              m_remaining; // cycles until the expected done pulse
  int              m_lc;
  int              m_total;
  bit              m_oob;
  bit              m_go;

  task automatic model_accept();
    logic [COLS-1:0] g [ROWS];
    logic [9:0]      xs [4];
    logic [9:0]      ys [4];
    int k, dst, dx, dy;
    xs[0] = bus.square1x; ys[0] = bus.square1y;
    xs[1] = bus.square2x; ys[1] = bus.square2y;
    xs[2] = bus.square3x; ys[2] = bus.square3y;
    xs[3] = bus.square4x; ys[3] = bus.square4y;
    for (int n = 0; n < 4; n++) begin
      dx = int'(xs[n]) - 240;
      dy = int'(ys[n]) - 80;
      if (dx < 0 || dy < 0 || dx / 16 >= COLS || dy / 16 >= ROWS) m_oob = 1'b1;
      else m_grid[dy / 16][dx / 16] = 1'b1;
    end
    // Keep non-full rows in order, packed against the bottom
    k   = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (m_grid[r] == '1) k++;
      else begin
        g[dst] = m_grid[r];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) g[r] = '0;
    m_grid      = g;
    m_lc        = k;
    m_total     = (m_total + k > 65535) ? 65535 : m_total + k;
    if (m_grid[0] != '0) m_go = 1'b1;
    m_remaining = 5 + ROWS + 2 * k;
  endtask

  // Compare process: inputs seen here are those the preceding posedge sampled
  always @(negedge Clk) begin
    logic [COLS-1:0] exp_rd;
    bit              exp_done;
    if (!Reset) begin
      for (int i = 0; i < ROWS; i++) m_grid[i] = '0;
      m_remaining = 0;
      m_lc        = 0;
      m_total     = 0;
      m_oob       = 1'b0;
      m_go        = 1'b0;
      check("rst rd_cells", bus.rd_cells, 0);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst lines_cleared", bus.lines_cleared, 0);
      check("rst lines_total", bus.lines_total, 0);
      check("rst oob", bus.oob, 0);
      check("rst game_over", bus.game_over, 0);
    end else begin
      exp_done = 1'b0;
      if (m_remaining == 0) begin
        exp_rd = (bus.rd_row < ROWS) ? m_grid[bus.rd_row] : '0;
        check("cmp rd_cells", bus.rd_cells, exp_rd);
        if (bus.clear_board) begin
          for (int i = 0; i < ROWS; i++) m_grid[i] = '0;
          m_oob = 1'b0;
          m_go  = 1'b0;
        end else if (bus.at_bottom) begin
          model_accept();
        end
      end else begin
        m_remaining--;
        exp_done = (m_remaining == 0);
      end
      check("cmp busy", bus.busy, (m_remaining != 0) ? 1 : 0);
      check("cmp done", bus.done, exp_done);
      if (m_remaining == 0) begin
        check("cmp lines_cleared", bus.lines_cleared, m_lc);
        check("cmp lines_total", bus.lines_total, m_total);
        check("cmp oob", bus.oob, m_oob);
        check("cmp game_over", bus.game_over, m_go);
      end
    end
  end

  // ---------------- stimulus helpers (enter and leave at negedge+1) ----------------
  function automatic logic [9:0] px(input int c);
    return 10'(240 + 16 * c);
  endfunction

  function automatic logic [9:0] py(input int r);
    return 10'(80 + 16 * r);
  endfunction

  task automatic set_sq(input int c0, input int r0, input int c1, input int r1,
                        input int c2, input int r2, input int c3, input int r3);
    bus.square1x = px(c0); bus.square1y = py(r0);
    bus.square2x = px(c1); bus.square2y = py(r1);
    bus.square3x = px(c2); bus.square3y = py(r2);
    bus.square4x = px(c3); bus.square4y = py(r3);
  endtask

  task automatic drop(input int c0, input int r0, input int c1, input int r1,
                      input int c2, input int r2, input int c3, input int r3,
                      input int exp_lat, input string tag);
    int n;
    set_sq(c0, r0, c1, r1, c2, r2, c3, r3);
    bus.at_bottom = 1'b1;
    @(negedge Clk);
    #1 bus.at_bottom = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.done && n < 200);
    check({tag, " latency"}, n, exp_lat);
    $display("drop %s: done after %0d cycles, lines_cleared=%0d lines_total=%0d",
             tag, n, bus.lines_cleared, bus.lines_total);
    #1;
  endtask

  task automatic expect_row(input int r, input logic [COLS-1:0] exp, input string name);
    bus.rd_row = 5'(r);
    @(negedge Clk);
    check(name, bus.rd_cells, exp);
    #1;
  endtask

  task automatic clear_pulse();
    bus.clear_board = 1'b1;
    @(negedge Clk);
    #1 bus.clear_board = 1'b0;
    $display("clear_board pulse");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones, first;
    bus.clear_board = 1'b0;
    bus.at_bottom   = 1'b0;
    bus.rd_row      = '0;
    set_sq(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    #1 Reset = 1'b1;

    // T1: empty grid after reset
    for (int r = 0; r < ROWS; r++) expect_row(r, '0, $sformatf("T1 row%0d", r));
    check("T1 busy", bus.busy, 0);
    check("T1 done", bus.done, 0);

    // T2: four cells along the bottom row
    drop(0, 19, 1, 19, 2, 19, 3, 19, 25, "T2");
    check("T2 lines_cleared", bus.lines_cleared, 0);
    check("T2 model row19", m_grid[19], 10'h00F);
    expect_row(19, 10'h00F, "T2 row19");

    // T3: one full row, row above drops into it
    clear_pulse();
    expect_row(19, '0, "T3 wiped row19");
    drop(4, 19, 5, 19, 6, 19, 7, 19, 25, "T3 pre a");
    drop(8, 19, 9, 19, 0, 18, 9, 19, 25, "T3 pre b");
    expect_row(19, 10'h3F0, "T3 pre row19");
    expect_row(18, 10'h001, "T3 pre row18");
    drop(0, 19, 1, 19, 2, 19, 3, 19, 27, "T3");
    check("T3 lines_cleared", bus.lines_cleared, 1);
    check("T3 lines_total", bus.lines_total, 1);
    expect_row(19, 10'h001, "T3 row19");
    expect_row(18, 10'h000, "T3 row18");

    // T4: four rows cleared by a vertical I
    clear_pulse();
    for (int c = 1; c < COLS; c++) drop(c, 16, c, 17, c, 18, c, 19, 25, "T4 pre");
    for (int r = 16; r < ROWS; r++) expect_row(r, 10'h3FE, $sformatf("T4 pre row%0d", r));
    expect_row(20, '0, "T4 rd_row 20");
    expect_row(31, '0, "T4 rd_row 31");
    drop(0, 16, 0, 17, 0, 18, 0, 19, 33, "T4");
    check("T4 lines_cleared", bus.lines_cleared, 4);
    check("T4 lines_total", bus.lines_total, 5);
    for (int r = 16; r < ROWS; r++) expect_row(r, '0, $sformatf("T4 row%0d", r));

    // T5: one square left of the grid, plus a landing pulse while busy
    set_sq(-1, 10, 5, 10, 6, 10, 7, 10);
    bus.at_bottom = 1'b1;
    @(negedge Clk);
    #1 bus.at_bottom = 1'b0;
    dones = 0;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      if (bus.done) begin
        dones++;
        if (first == 0) first = i;
      end
      #1;
      if (i == 4) begin
        set_sq(0, 0, 1, 0, 2, 0, 3, 0);
        bus.at_bottom = 1'b1;
      end
      if (i == 5) bus.at_bottom = 1'b0;
    end
    $display("drop T5: done pulses=%0d first at %0d cycles, oob=%0d", dones, first, bus.oob);
    check("T5 done pulses", dones, 1);
    check("T5 latency", first, 25);
    check("T5 oob", bus.oob, 1);
    expect_row(10, 10'h0E0, "T5 row10");
    expect_row(0, '0, "T5 ignored piece row0");

    // clear_board and at_bottom together: the wipe wins, no sequence starts
    set_sq(0, 5, 1, 5, 2, 5, 3, 5);
    bus.clear_board = 1'b1;
    bus.at_bottom   = 1'b1;
    @(negedge Clk);
    #1;
    bus.clear_board = 1'b0;
    bus.at_bottom   = 1'b0;
    $display("clear_board with at_bottom");
    check("clear wins busy", bus.busy, 0);
    check("clear wins oob", bus.oob, 0);
    expect_row(10, '0, "clear wins row10");
    expect_row(5, '0, "clear wins row5");

    // T6: reaching row 0 ends the game; reset mid-scan wipes everything
    drop(3, 0, 4, 0, 4, 1, 5, 1, 25, "T6");
    check("T6 game_over", bus.game_over, 1);
    expect_row(0, 10'h018, "T6 row0");
    set_sq(0, 5, 1, 5, 2, 5, 3, 5);
    bus.at_bottom = 1'b1;
    @(negedge Clk);
    #1 bus.at_bottom = 1'b0;
    repeat (10) @(negedge Clk);
    #1;
    check("T6 busy before reset", bus.busy, 1);
    Reset = 1'b0;
    dones = 0;
    repeat (3) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    #1 Reset = 1'b1;
    repeat (40) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    #1;
    $display("reset mid-scan: done pulses=%0d game_over=%0d", dones, bus.game_over);
    check("T6 no done after reset", dones, 0);
    check("T6 game_over cleared", bus.game_over, 0);
    expect_row(0, '0, "T6 row0 after reset");
    expect_row(1, '0, "T6 row1 after reset");
    expect_row(5, '0, "T6 row5 after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
